heartbeat_generator: RTL and testbench

HEARTBEAT_GENERATOR -- requirements
Module: heartbeat_generator

---
 rtl/wd_pkg.sv | 18 +
 rtl/period_tick.sv | 30 +++
 rtl/heartbeat_generator.sv | 98 +++++++++
 tb/tb_heartbeat_generator.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/wd_pkg.sv
// rtl/wd_pkg.sv - shared heartbeat/watchdog types and defaults
package wd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_RUN       = 2'd1,
    ST_STALLED   = 2'd2,
    ST_SUSPENDED = 2'd3
  } hb_state_t;

  localparam int unsigned DEFAULT_PERIOD_CYCLES = 1000;
  localparam int unsigned DEFAULT_STALL_LIMIT   = 4;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/period_tick.sv
// rtl/period_tick.sv - 32-bit period counter with terminal-count strobe
module period_tick
  import wd_pkg::*;
#(
  parameter int unsigned PERIOD_CYCLES = DEFAULT_PERIOD_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic tc
);

  localparam logic [31:0] LAST = 32'(PERIOD_CYCLES - 1);

  logic [31:0] count;

  // Dropping run parks the counter at 0, so every new run starts a fresh period.
  always_ff @(posedge clk) begin
    if (rst || !run) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + 32'd1;
    end
  end

  assign tc = run && (count == LAST);

endmodule

// File: rtl/heartbeat_generator.sv
// rtl/heartbeat_generator.sv - activity-gated watchdog heartbeat with stall and suspend handling
module heartbeat_generator
  import wd_pkg::*;
#(
  parameter int unsigned PERIOD_CYCLES = DEFAULT_PERIOD_CYCLES,
  parameter int unsigned STALL_LIMIT   = DEFAULT_STALL_LIMIT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        activity,
  input  logic        suspend,
  output logic        heartbeat,
  output logic        stalled,
  output logic [15:0] beat_count,
  output logic [7:0]  miss_count
);

  localparam logic [7:0] LIMIT = 8'(STALL_LIMIT);

  hb_state_t  state;
  logic       act_flag;
  logic       run;
  logic       tc;
  logic       seen;
  logic [7:0] miss_next;

  // Counter is cleared on the same edge that disable, suspend or reset is sampled.
  assign run = !rst && enable && !suspend &&
               ((state == ST_RUN) || (state == ST_STALLED));

  period_tick #(
    .PERIOD_CYCLES(PERIOD_CYCLES)
  ) u_period_tick (
    .clk(clk),
    .rst(rst),
    .run(run),
    .tc (tc)
  );

  assign seen      = act_flag | activity;
  assign miss_next = sat_inc8(miss_count);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      act_flag   <= 1'b0;
      heartbeat  <= 1'b0;
      stalled    <= 1'b0;
      beat_count <= '0;
      miss_count <= '0;
    end else begin
      heartbeat <= 1'b0;
      if (!enable) begin
        state      <= ST_IDLE;
        act_flag   <= 1'b0;
        miss_count <= '0;
        stalled    <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: state <= suspend ? ST_SUSPENDED : ST_RUN;
          ST_SUSPENDED: begin
            act_flag <= 1'b0;
            if (!suspend) state <= ST_RUN;
          end
          default: begin
            if (suspend) begin
              state    <= ST_SUSPENDED;
              act_flag <= 1'b0;
              stalled  <= 1'b0;
            end else if (tc) begin
              act_flag <= 1'b0;
              if (seen) begin
                miss_count <= '0;
                if (state == ST_RUN) begin
                  heartbeat  <= 1'b1;
                  beat_count <= beat_count + 16'd1;
                end else begin
                  state   <= ST_RUN;
                  stalled <= 1'b0;
                end
              end else begin
                miss_count <= miss_next;
                if (miss_next >= LIMIT) begin
                  state   <= ST_STALLED;
                  stalled <= 1'b1;
                end
              end
            end else if (activity) begin
              act_flag <= 1'b1;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_heartbeat_generator.sv
// tb/tb_heartbeat_generator.sv - scoreboard bench for heartbeat_generator
module tb_heartbeat_generator;
  import wd_pkg::*;

  localparam int P = 8;
  localparam int L = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        activity = 1'b0;
  logic        suspend = 1'b0;
  logic        heartbeat;
  logic        stalled;
  logic [15:0] beat_count;
  logic [7:0]  miss_count;

  always #5 clk = ~clk;

  heartbeat_generator #(
    .PERIOD_CYCLES(P),
    .STALL_LIMIT(L)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .activity  (activity),
    .suspend   (suspend),
    .heartbeat (heartbeat),
    .stalled   (stalled),
    .beat_count(beat_count),
    .miss_count(miss_count)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int at;
    int beats;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   tests = 0;
  int   fails = 0;
  logic hb_prev = 1'b0;

  always @(negedge clk) begin
    if (heartbeat) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_pulse: pulse at cyc=%0d beat_count=%0d, required no pulse", cyc, beat_count);
      end else begin
        e = sb.pop_front();
        if (cyc != e.at || int'(beat_count) != e.beats) begin
          fails++;
          $display("FAIL pulse: got cyc=%0d beat_count=%0d, required cyc=%0d beat_count=%0d",
                   cyc, beat_count, e.at, e.beats);
        end
      end
      if (hb_prev) begin
        fails++;
        $display("FAIL pulse_width: heartbeat high two cycles in a row at cyc=%0d", cyc);
      end
    end
    hb_prev = heartbeat;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_to(input int t);
    while (cyc < t) tick(1);
  endtask

  task automatic do_reset();
    rst = 1'b1; enable = 1'b0; activity = 1'b0; suspend = 1'b0;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic push(input int at, input int beats);
    sb.push_back('{at, beats});
  endtask

  task automatic chk(input string nm, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d (cyc=%0d)", nm, act, req, cyc);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  int e0;
  int r;
  int en_seq[9] = '{1, 1, 1, 1, 1, 1, 0, 0, 1};

  initial begin
    // normal run
    do_reset();
    chk("reset_heartbeat", int'(heartbeat), 0);
    chk("reset_stalled", int'(stalled), 0);
    chk("reset_beat_count", int'(beat_count), 0);
    chk("reset_miss_count", int'(miss_count), 0);
    chk("reset_state", int'(dut.state), int'(ST_IDLE));
    enable = 1'b1;
    e0 = cyc + 1;
    push(e0 + 8, 1); push(e0 + 16, 2); push(e0 + 24, 3);
    for (int i = 0; i < 25; i++) begin
      activity = (i % 3 == 1);
      tick(1);
    end
    activity = 1'b0;
    tick(1);
    chk("run_beat_count", int'(beat_count), 3);

    // stall and recovery
    do_reset();
    enable = 1'b1;
    e0 = cyc + 1;
    run_to(e0 + 8);
    chk("stall_miss1", int'(miss_count), 1);
    chk("stall_not_yet", int'(stalled), 0);
    run_to(e0 + 16);
    chk("stall_miss2", int'(miss_count), 2);
    chk("stall_set", int'(stalled), 1);
    activity = 1'b1; tick(1); activity = 1'b0;
    run_to(e0 + 24);
    chk("recover_stalled", int'(stalled), 0);
    chk("recover_miss", int'(miss_count), 0);
    chk("recover_no_beat", int'(beat_count), 0);
    push(e0 + 32, 1);
    activity = 1'b1; tick(1); activity = 1'b0;
    run_to(e0 + 33);
    chk("recover_beat", int'(beat_count), 1);

    // activity only on the TC cycle
    do_reset();
    enable = 1'b1;
    e0 = cyc + 1;
    run_to(e0 + 8);
    chk("tcact_miss1", int'(miss_count), 1);
    run_to(e0 + 15);
    push(e0 + 16, 1);
    activity = 1'b1; tick(1); activity = 1'b0;
    chk("tcact_miss0", int'(miss_count), 0);
    tick(1);
    chk("tcact_beat", int'(beat_count), 1);

    // suspend on the TC cycle
    do_reset();
    enable = 1'b1;
    e0 = cyc + 1;
    run_to(e0 + 2);
    activity = 1'b1; tick(1); activity = 1'b0;
    run_to(e0 + 7);
    suspend = 1'b1; tick(1);
    chk("susp_state", int'(dut.state), int'(ST_SUSPENDED));
    activity = 1'b1; tick(1); activity = 1'b0;
    tick(1);
    suspend = 1'b0;
    r = cyc + 1;
    push(r + 8, 1);
    tick(1);
    chk("resume_state", int'(dut.state), int'(ST_RUN));
    run_to(r + 2);
    activity = 1'b1; tick(1); activity = 1'b0;
    run_to(r + 9);
    chk("resume_beat", int'(beat_count), 1);

    // enable sequence with reset on cycle 0
    e0 = cyc + 1;
    push(e0 + 16, 1);
    activity = 1'b1;
    for (int i = 0; i < 9; i++) begin
      rst = (i == 0);
      enable = en_seq[i][0];
      tick(1);
      if (i == 6 || i == 7) chk("disable_idle", int'(dut.state), int'(ST_IDLE));
    end
    run_to(e0 + 18);
    enable = 1'b0;
    tick(2);
    chk("disable2_idle", int'(dut.state), int'(ST_IDLE));
    chk("disable_beat_held", int'(beat_count), 1);
    enable = 1'b1;
    r = cyc + 1;
    push(r + 8, 2);
    run_to(r + 9);
    activity = 1'b0;
    chk("reenable_beat", int'(beat_count), 2);

    // reset while stalled
    do_reset();
    enable = 1'b1;
    e0 = cyc + 1;
    run_to(e0 + 16);
    chk("rststall_stalled", int'(stalled), 1);
    chk("rststall_miss", int'(miss_count), 2);
    run_to(e0 + 17);
    activity = 1'b1; tick(1); activity = 1'b0;
    run_to(e0 + 19);
    rst = 1'b1; tick(1); rst = 1'b0;
    chk("rst_heartbeat", int'(heartbeat), 0);
    chk("rst_stalled", int'(stalled), 0);
    chk("rst_beat_count", int'(beat_count), 0);
    chk("rst_miss_count", int'(miss_count), 0);
    run_to(e0 + 31);
    chk("post_rst_miss", int'(miss_count), 1);

    tick(2);
    chk("missing_pulses", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
